// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stability counter,
// press/release strobes. Define KEY_REPEAT_EN to add per-channel auto-repeat strobes.
module key_debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 15_000_000,
    parameter int IDLE_LEVEL      = 1,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] key_out,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_release,
    output logic [CHANNELS-1:0] key_repeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CHANNELS-1:0] IDLE_VEC =
        (IDLE_LEVEL != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] key_out_q, key_out_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        key_out_d = key_out_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == key_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Accept the new level; the strobe lands in the same cycle key_out shows it.
                key_out_d[i] = sync2_q[i];
                cnt_d[i]     = '0;
                if (sync2_q[i] != IDLE_VEC[i]) press_d[i]   = 1'b1;
                else                           release_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= IDLE_VEC;
            sync2_q   <= IDLE_VEC;
            key_out_q <= IDLE_VEC;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_REPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_HIT    = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [HW-1:0]       hold_q [CHANNELS];
    logic [HW-1:0]       hold_d [CHANNELS];
    logic [CHANNELS-1:0] repeat_q, repeat_d;

    // hold_q counts cycles since the press cycle; it is zero in the press cycle itself.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hold_d[i] = '0;
            if (key_out_q[i] != IDLE_VEC[i]) begin
                if (hold_q[i] + HW'(1) == HOLD_HIT) begin
                    repeat_d[i] = ~release_d[i];
                    hold_d[i]   = HOLD_RELOAD;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_q <= '0;
            for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
        end else begin
            repeat_q <= repeat_d;
            for (int i = 0; i < CHANNELS; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign key_repeat = repeat_q;
`else
    assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: sliding-window reference model checked every cycle,
// plus directed latency/boundary checks with hand-computed edge counts.
module tb_key_debounce_multi;

    localparam int CH   = 4;
    localparam int D    = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] key_in;
    logic [CH-1:0] key_out, key_press, key_release, key_repeat;

    int n_cmp = 0;
    int n_err = 0;

    key_debounce_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_out(key_out),
        .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted at edge t when the raw samples taken at edges
    // t-2 .. t-D-1 all disagree with the current debounced level.
    logic [CH-1:0] m_hist [0:D];
    logic [CH-1:0] m_out, m_press, m_rel, m_rep;
    int            m_age [CH];

    always @(posedge clk or negedge rst_n) begin : model
        logic [CH-1:0] nout, np, nr, nrep;
        bit            differ;
        int            nage;
        if (!rst_n) begin
            for (int k = 0; k <= D; k++) m_hist[k] <= '1;
            m_out <= '1; m_press <= '0; m_rel <= '0; m_rep <= '0;
            for (int c = 0; c < CH; c++) m_age[c] <= 0;
        end else begin
            nout = m_out; np = '0; nr = '0; nrep = '0;
            for (int c = 0; c < CH; c++) begin
                differ = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (m_hist[k][c] == m_out[c]) differ = 1'b0;
                if (differ) begin
                    nout[c] = ~m_out[c];
                    if (nout[c] == 1'b0) np[c] = 1'b1;
                    else                 nr[c] = 1'b1;
                end
                if (np[c])             nage = 0;
                else if (nout[c] == 0) nage = m_age[c] + 1;
                else                   nage = 0;
                nrep[c] = REP_EN && !nout[c] && !np[c] && nage >= HOLD
                          && ((nage - HOLD) % REP == 0);
                m_age[c] <= nage;
            end
            m_out <= nout; m_press <= np; m_rel <= nr; m_rep <= nrep;
            m_hist[0] <= key_in;
            for (int k = 1; k <= D; k++) m_hist[k] <= m_hist[k-1];
        end
    end

    always @(negedge clk) begin
        check("key_out",     {28'd0, key_out},     {28'd0, m_out});
        check("key_press",   {28'd0, key_press},   {28'd0, m_press});
        check("key_release", {28'd0, key_release}, {28'd0, m_rel});
        check("key_repeat",  {28'd0, key_repeat},  {28'd0, m_rep});
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one channel at a negedge and count posedges until key_out follows.
    task automatic measure(input int ch, input logic val, input int exp_edges, input string name);
        int n;
        @(negedge clk);
        key_in[ch] = val;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (key_out[ch] !== val && n < 40);
        check({name, "_latency"}, n, exp_edges);
        if (val == 1'b0) check({name, "_press"},   {31'd0, key_press[ch]},   32'd1);
        else             check({name, "_release"}, {31'd0, key_release[ch]}, 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 4'hF;
        wait_neg(3);
        rst_n = 1'b1;
        check("reset_key_out", {28'd0, key_out}, 32'hF);

        // Clean press and release on ch0
        measure(0, 1'b0, 10, "ch0_press");
        check("ch0_others", {29'd0, key_out[3:1]}, 32'h7);
        wait_neg(20);
        measure(0, 1'b1, 10, "ch0_release");

        // Bounce on ch1: toggles every 3 cycles, then settles low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key_in[1] = ~key_in[1];
            wait_neg(2);
        end
        wait_neg(12);
        check("ch1_bounce_stable", {31'd0, key_out[1]}, 32'd1);
        measure(1, 1'b0, 10, "ch1_settle");

        // Simultaneous press ch2 / release ch3
        @(negedge clk); key_in[3] = 1'b0;
        wait_neg(15);
        check("ch3_held", {31'd0, key_out[3]}, 32'd0);
        key_in[2] = 1'b0; key_in[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("ch2_press_same", {31'd0, key_press[2]},   32'd1);
        check("ch3_rel_same",   {31'd0, key_release[3]}, 32'd1);
        wait_neg(5);

        // Boundary: 7 low samples rejected, 8 accepted
        key_in[0] = 1'b0; wait_neg(7); key_in[0] = 1'b1;
        wait_neg(15);
        check("ch0_seven", {31'd0, key_out[0]}, 32'd1);
        key_in[0] = 1'b0; wait_neg(8); key_in[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ch0_eight_out",   {31'd0, key_out[0]},   32'd0);
        check("ch0_eight_press", {31'd0, key_press[0]}, 32'd1);
        wait_neg(15);

        // Long hold on ch0 (auto-repeat window when enabled), then release
        key_in[0] = 1'b0; wait_neg(60);
        key_in[0] = 1'b1; wait_neg(20);
        check("ch0_after_hold", {31'd0, key_out[0]}, 32'd1);

        // Mid-run reset with ch0 counting and ch1/ch2 held active
        key_in[0] = 1'b0; wait_neg(4);
        rst_n = 1'b0;
        #1;
        check("async_reset_out",   {28'd0, key_out},   32'hF);
        check("async_reset_press", {28'd0, key_press}, 32'h0);
        wait_neg(3);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_through_reset", {28'd0, key_press}, 32'h7);
        wait_neg(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
